sdram_arbiter: RTL and testbench

- Central scheduler inside the SDRAM subsystem: owns the single SDRAM command/address bus.
- Sequences power-up init, then arbitrates auto-refresh, write-burst and read-burst engines (priority refresh > write > read).
- Generates the periodic refresh request itself; latches the one-cycle wr_trig/rd_trig pulses from cmd_decode.
- Muxes the granted engine's command, address and bank onto the SDRAM pins.

---
 rtl/sdram_arbiter_if.sv | 41 ++++
 rtl/sdram_arbiter.sv | 138 +++++++++++++
 tb/tb_sdram_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_if.sv
// Signal bundle between the SDRAM arbiter and its init/refresh/write/read engines and pins.
// The slave modport is the arbiter's view; master is the engine/pin side.
interface sdram_arbiter_if;
  logic        init_end;
  logic [3:0]  init_cmd;
  logic [11:0] init_addr;
  logic        wr_trig;
  logic        rd_trig;
  logic        ref_end;
  logic        wr_end;
  logic        rd_end;
  logic [3:0]  ref_cmd;
  logic [11:0] ref_addr;
  logic [3:0]  wr_cmd;
  logic [11:0] wr_addr;
  logic [1:0]  wr_bank;
  logic [3:0]  rd_cmd;
  logic [11:0] rd_addr;
  logic [1:0]  rd_bank;
  logic        ref_en;
  logic        wr_en;
  logic        rd_en;
  logic        ref_req;
  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_bank;

  modport slave (
    input  init_end, init_cmd, init_addr, wr_trig, rd_trig,
    input  ref_end, wr_end, rd_end,
    input  ref_cmd, ref_addr, wr_cmd, wr_addr, wr_bank, rd_cmd, rd_addr, rd_bank,
    output ref_en, wr_en, rd_en, ref_req, sdram_cmd, sdram_addr, sdram_bank
  );

  modport master (
    output init_end, init_cmd, init_addr, wr_trig, rd_trig,
    output ref_end, wr_end, rd_end,
    output ref_cmd, ref_addr, wr_cmd, wr_addr, wr_bank, rd_cmd, rd_addr, rd_bank,
    input  ref_en, wr_en, rd_en, ref_req, sdram_cmd, sdram_addr, sdram_bank
  );
endinterface

// File: rtl/sdram_arbiter.sv
// SDRAM command-bus scheduler: power-up init, then refresh > write > read arbitration,
// with a self-timed refresh request and a state-driven command/address mux.
module sdram_arbiter #(
  parameter int REF_CYCLES = 780,
  parameter int CNT_W      = 10
) (
  input logic           sclk,
  input logic           reset,
  sdram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REF_CYCLES - 1);
  localparam logic [3:0]       CMD_NOP  = 4'b0111;

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] ref_cnt_r;
  logic             ref_pend_r;
  logic             wr_pend_r;
  logic             rd_pend_r;
  logic             active_s;
  logic             cnt_wrap_s;
  logic             grant_ref_s;
  logic             grant_wr_s;
  logic             grant_rd_s;

  assign active_s    = (state_r != ST_INIT);
  assign cnt_wrap_s  = active_s && (ref_cnt_r == CNT_LAST);
  assign grant_ref_s = (state_r == ST_IDLE) && ref_pend_r;
  assign grant_wr_s  = (state_r == ST_IDLE) && !ref_pend_r && wr_pend_r;
  assign grant_rd_s  = (state_r == ST_IDLE) && !ref_pend_r && !wr_pend_r && rd_pend_r;
  assign bus.ref_req = ref_pend_r;

  // state register
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state: engines run until their own end pulse, no preemption
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_INIT:  if (bus.init_end) state_s = ST_IDLE;  else state_s = ST_INIT;
      ST_IDLE: begin
        if (grant_ref_s)     state_s = ST_AREF;
        else if (grant_wr_s) state_s = ST_WRITE;
        else if (grant_rd_s) state_s = ST_READ;
        else                 state_s = ST_IDLE;
      end
      ST_AREF:  if (bus.ref_end) state_s = ST_IDLE; else state_s = ST_AREF;
      ST_WRITE: if (bus.wr_end)  state_s = ST_IDLE; else state_s = ST_WRITE;
      ST_READ:  if (bus.rd_end)  state_s = ST_IDLE; else state_s = ST_READ;
      default:  state_s = ST_INIT;
    endcase
  end

  // refresh interval counter, frozen at zero during init
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      ref_cnt_r <= '0;
    end else if (!active_s || cnt_wrap_s) begin
      ref_cnt_r <= '0;
    end else begin
      ref_cnt_r <= ref_cnt_r + CNT_W'(1);
    end
  end

  // pending flags: a new request on the granting edge survives the clear
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      ref_pend_r <= 1'b0;
      wr_pend_r  <= 1'b0;
      rd_pend_r  <= 1'b0;
    end else begin
      if (cnt_wrap_s)                 ref_pend_r <= 1'b1;
      else if (grant_ref_s)           ref_pend_r <= 1'b0;
      else                            ref_pend_r <= ref_pend_r;
      if (active_s && bus.wr_trig)    wr_pend_r  <= 1'b1;
      else if (grant_wr_s)            wr_pend_r  <= 1'b0;
      else                            wr_pend_r  <= wr_pend_r;
      if (active_s && bus.rd_trig)    rd_pend_r  <= 1'b1;
      else if (grant_rd_s)            rd_pend_r  <= 1'b0;
      else                            rd_pend_r  <= rd_pend_r;
    end
  end

  // grant decode and pin mux
  always_comb begin
    bus.ref_en     = 1'b0;
    bus.wr_en      = 1'b0;
    bus.rd_en      = 1'b0;
    bus.sdram_cmd  = CMD_NOP;
    bus.sdram_addr = 12'd0;
    bus.sdram_bank = 2'd0;
    case (state_r)
      ST_INIT: begin
        bus.sdram_cmd  = bus.init_cmd;
        bus.sdram_addr = bus.init_addr;
      end
      ST_AREF: begin
        bus.ref_en     = 1'b1;
        bus.sdram_cmd  = bus.ref_cmd;
        bus.sdram_addr = bus.ref_addr;
      end
      ST_WRITE: begin
        bus.wr_en      = 1'b1;
        bus.sdram_cmd  = bus.wr_cmd;
        bus.sdram_addr = bus.wr_addr;
        bus.sdram_bank = bus.wr_bank;
      end
      ST_READ: begin
        bus.rd_en      = 1'b1;
        bus.sdram_cmd  = bus.rd_cmd;
        bus.sdram_addr = bus.rd_addr;
        bus.sdram_bank = bus.rd_bank;
      end
      ST_IDLE: begin
        bus.sdram_cmd  = CMD_NOP;
      end
      default: begin
        bus.sdram_cmd  = CMD_NOP;
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios plus random traffic, every cycle
// compared against a grant/pending model driven by cycle arithmetic.
module tb_sdram_arbiter;
  localparam int R      = 780;
  localparam int O_IDLE = 0;
  localparam int O_REF  = 1;
  localparam int O_WR   = 2;
  localparam int O_RD   = 3;

  logic sclk  = 1'b0;
  logic reset = 1'b0;
  sdram_arbiter_if bus();

  sdram_arbiter #(.REF_CYCLES(R), .CNT_W(10)) dut (
    .sclk  (sclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 sclk = ~sclk;

  int checks = 0;
  int errors = 0;

  // model: who owns the bus, what is waiting, cycles since init finished
  bit m_ready = 1'b0;
  int m_owner = O_IDLE;
  int m_since = 0;
  bit m_ref = 1'b0;
  bit m_wr  = 1'b0;
  bit m_rd  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ready = 1'b0;
    m_owner = O_IDLE;
    m_since = 0;
    m_ref = 1'b0;
    m_wr  = 1'b0;
    m_rd  = 1'b0;
  endtask

  task automatic model_edge();
    int nxt;
    if (!reset) begin
      model_reset();
    end else if (!m_ready) begin
      if (bus.init_end) begin
        m_ready = 1'b1;
        m_since = 0;
      end
    end else begin
      m_since++;
      nxt = m_owner;
      if (m_owner == O_IDLE) begin
        if (m_ref)     begin nxt = O_REF; m_ref = 1'b0; end
        else if (m_wr) begin nxt = O_WR;  m_wr  = 1'b0; end
        else if (m_rd) begin nxt = O_RD;  m_rd  = 1'b0; end
      end else if ((m_owner == O_REF && bus.ref_end) ||
                   (m_owner == O_WR  && bus.wr_end)  ||
                   (m_owner == O_RD  && bus.rd_end)) begin
        nxt = O_IDLE;
      end
      if (m_since % R == 0) m_ref = 1'b1;
      if (bus.wr_trig) m_wr = 1'b1;
      if (bus.rd_trig) m_rd = 1'b1;
      m_owner = nxt;
    end
  endtask

  function automatic logic [21:0] exp_out();
    logic [3:0]  c;
    logic [11:0] a;
    logic [1:0]  b;
    c = 4'b0111; a = 12'd0; b = 2'd0;
    if (!m_ready) begin
      c = bus.init_cmd; a = bus.init_addr;
    end else begin
      case (m_owner)
        O_REF: begin c = bus.ref_cmd; a = bus.ref_addr; end
        O_WR:  begin c = bus.wr_cmd;  a = bus.wr_addr; b = bus.wr_bank; end
        O_RD:  begin c = bus.rd_cmd;  a = bus.rd_addr; b = bus.rd_bank; end
        default: ;
      endcase
    end
    return {m_ready && m_owner == O_REF, m_ready && m_owner == O_WR,
            m_ready && m_owner == O_RD, m_ref, c, a, b};
  endfunction

  task automatic check_outputs();
    chk("outputs", {10'd0, bus.ref_en, bus.wr_en, bus.rd_en, bus.ref_req,
                    bus.sdram_cmd, bus.sdram_addr, bus.sdram_bank}, {10'd0, exp_out()});
  endtask

  task automatic randomize_data();
    bus.init_cmd  = 4'($urandom);  bus.init_addr = 12'($urandom);
    bus.ref_cmd   = 4'($urandom);  bus.ref_addr  = 12'($urandom);
    bus.wr_cmd    = 4'($urandom);  bus.wr_addr   = 12'($urandom);
    bus.wr_bank   = 2'($urandom);
    bus.rd_cmd    = 4'($urandom);  bus.rd_addr   = 12'($urandom);
    bus.rd_bank   = 2'($urandom);
  endtask

  // one clock: model follows the edge, outputs compared 1 ns later, pulses dropped
  task automatic step();
    @(posedge sclk);
    model_edge();
    #1;
    check_outputs();
    bus.init_end = 1'b0; bus.wr_trig = 1'b0; bus.rd_trig = 1'b0;
    bus.ref_end  = 1'b0; bus.wr_end  = 1'b0; bus.rd_end  = 1'b0;
    randomize_data();
    #1;
  endtask

  task automatic measure_ref_latency(output int lat);
    lat = 0;
    for (int i = 1; i <= 900; i++) begin
      step();
      if (bus.ref_en === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    bus.init_end = 1'b0; bus.wr_trig = 1'b0; bus.rd_trig = 1'b0;
    bus.ref_end  = 1'b0; bus.wr_end  = 1'b0; bus.rd_end  = 1'b0;
    randomize_data();
    model_reset();
    #12;
    chk("reset_flags", {28'd0, bus.ref_en, bus.wr_en, bus.rd_en, bus.ref_req}, 32'd0);
    check_outputs();
    step(); step();
    #2 reset = 1'b1;

    // init with stray triggers and an end pulse that must be ignored
    for (int i = 1; i <= 9; i++) begin
      bus.wr_trig = (i == 3);
      bus.rd_trig = (i == 3 || i == 5);
      bus.rd_end  = (i == 4);
      step();
    end
    bus.init_end = 1'b1;
    step();
    chk("idle_nop", {28'd0, bus.sdram_cmd}, 32'h7);
    chk("no_stale_grant", {29'd0, bus.ref_en, bus.wr_en, bus.rd_en}, 32'd0);
    measure_ref_latency(lat);
    chk("ref_latency", lat, 32'd781);
    bus.ref_end = 1'b1;
    step();
    chk("ref_end_release", {31'd0, bus.ref_en}, 32'd0);

    // single write
    step();
    bus.wr_trig = 1'b1;
    step();
    chk("wr_en_one_cycle", {31'd0, bus.wr_en}, 32'd0);
    step();
    chk("wr_en_two_cycles", {31'd0, bus.wr_en}, 32'd1);
    chk("wr_cmd_mux", {28'd0, bus.sdram_cmd}, {28'd0, bus.wr_cmd});
    chk("wr_bank_mux", {30'd0, bus.sdram_bank}, {30'd0, bus.wr_bank});
    step(); step();
    bus.wr_end = 1'b1;
    step();
    chk("wr_end_release", {31'd0, bus.wr_en}, 32'd0);

    // simultaneous triggers: write first, one idle cycle, then read
    step();
    bus.wr_trig = 1'b1; bus.rd_trig = 1'b1;
    step(); step();
    chk("both_write_first", {29'd0, bus.ref_en, bus.wr_en, bus.rd_en}, 32'b010);
    step();
    bus.wr_end = 1'b1;
    step();
    chk("gap_idle", {29'd0, bus.ref_en, bus.wr_en, bus.rd_en}, 32'd0);
    step();
    chk("then_read", {31'd0, bus.rd_en}, 32'd1);
    chk("rd_bank_mux", {30'd0, bus.sdram_bank}, {30'd0, bus.rd_bank});
    bus.rd_end = 1'b1;
    step();

    // refresh expires mid-write while a read waits
    for (int i = 0; i < 900; i++) begin
      if (m_since % R == R - 10) break;
      step();
    end
    bus.wr_trig = 1'b1;
    step();
    bus.rd_trig = 1'b1;
    step();
    chk("write_granted", {31'd0, bus.wr_en}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.ref_req === 1'b1) break;
    end
    chk("ref_req_in_write", {31'd0, bus.ref_req}, 32'd1);
    chk("no_preempt", {31'd0, bus.wr_en}, 32'd1);
    bus.wr_end = 1'b1;
    step();
    chk("idle_after_wr", {29'd0, bus.ref_en, bus.wr_en, bus.rd_en}, 32'd0);
    step();
    chk("aref_before_read", {29'd0, bus.ref_en, bus.wr_en, bus.rd_en}, 32'b100);
    chk("ref_req_cleared", {31'd0, bus.ref_req}, 32'd0);
    bus.ref_end = 1'b1;
    step(); step();
    chk("read_after_aref", {31'd0, bus.rd_en}, 32'd1);
    bus.rd_end = 1'b1;
    step();

    // random traffic, including end pulses from non-granted engines
    for (int i = 0; i < 1500; i++) begin
      bus.wr_trig  = ($urandom_range(0, 19) == 0);
      bus.rd_trig  = ($urandom_range(0, 19) == 0);
      bus.ref_end  = ($urandom_range(0, 5) == 0);
      bus.wr_end   = ($urandom_range(0, 5) == 0);
      bus.rd_end   = ($urandom_range(0, 5) == 0);
      bus.init_end = ($urandom_range(0, 49) == 0);
      step();
    end
    for (int i = 0; i < 100; i++) begin
      if (m_owner == O_IDLE && !m_ref && !m_wr && !m_rd) break;
      bus.ref_end = 1'b1; bus.wr_end = 1'b1; bus.rd_end = 1'b1;
      step();
    end

    // reset in the middle of a read
    bus.rd_trig = 1'b1;
    step(); step();
    chk("read_before_reset", {31'd0, bus.rd_en}, {31'd0, m_owner == O_RD});
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("rd_en_async_drop", {31'd0, bus.rd_en}, 32'd0);
    chk("init_cmd_on_reset", {28'd0, bus.sdram_cmd}, {28'd0, bus.init_cmd});
    check_outputs();
    step(); step();
    #2 reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.wr_trig = 1'b1;
      bus.rd_trig = (i == 2);
      step();
    end
    chk("waits_for_init", {29'd0, bus.ref_en, bus.wr_en, bus.rd_en}, 32'd0);
    bus.init_end = 1'b1;
    step();
    measure_ref_latency(lat);
    chk("ref_latency_after_reset", lat, 32'd781);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
